mips_core: RTL and testbench
============================

Name: mips_core

Overview:
- Single-cycle 32-bit MIPS-subset processor: fetch, decode, register read, ALU, data memory and write-back all complete in one clock.
- Contains a loadable instruction memory with an external write port, so a program is loaded while the core is held in reset.
- Exposes the PC, the current instruction and the write-back bus for debug and monitoring.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words; index = PC[7:2] / instAddress[7:2].
- DMEM_WORDS, 64, data memory depth in 32-bit words; index = effective address[7:2].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- inputInstruction  input  32  instruction word to load into instruction memory.
- writeInst  input  1  instruction memory write enable, sampled on the rising edge of clk.
- instAddress  input  32  byte address for the instruction load; word index = instAddress[7:2].
- ProgramCounter  output  32  current PC, a byte address.
- wordIn  output  32  instruction word fetched at the current PC (combinational read).
- write_reg  output  5  destination register index of the current instruction.
- write_data  output  32  value on the register write-back bus (ALU result, or load data for lw).

Behaviour:
- Reset (reset=0, asynchronous): PC=0; all 32 registers =0; data memory cleared.
  - Instruction memory is not cleared; it keeps accepting writes during reset.
- Instruction load: if writeInst=1 on a rising edge, imem[instAddress[7:2]] <= inputInstruction. This is independent of reset.
- Fetch: wordIn = imem[PC[7:2]], combinational. Index wraps modulo IMEM_WORDS.
- PC update, each rising edge with reset=1:
  - PC <= PC+4 by default.
  - beq taken: PC <= PC+4+(signext(imm16)<<2).
  - PC arithmetic is 32-bit modulo.
- Field decode: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm16=[15:0], sign-extended to 32 bits.
- Supported instructions (register writes occur on the rising edge; reads are combinational):
  - R-type (op=000000), rd <= result:
    - funct 000000: add, rs+rt. funct 100000 is also decoded as add.
    - funct 000001: sub, rs-rt. funct 100010 is also decoded as sub.
  - addi (op=001000): rt <= rs+signext(imm).
  - sw (op=101011): dmem[(rs+signext(imm))[7:2]] <= rt.
  - lw (op=100011 or op=010011): rt <= dmem[(rs+signext(imm))[7:2]].
  - beq (op=000100): taken when rs==rt; no register write.
- Arithmetic: two's complement, 32-bit wrap; no overflow trap.
- Register $0 is hardwired to 0; writes to it are discarded.
- write_reg: rd for R-type; rt for addi and lw; 0 for sw, beq and unknown opcodes.
- write_data: the ALU result, or load data for lw, regardless of write enable. For sw and beq it shows the ALU result.
- Unknown opcode or funct: treated as NOP. No register or memory write; PC+4.
- Read-during-write: a register read in the same cycle returns the old value. Write-back takes effect at the clock edge.
- Data memory: synchronous write, combinational read. Address bits [1:0] are ignored (no alignment fault).
- Reset asserted mid-program: PC, registers and data memory clear immediately; execution restarts at address 0 on release.

Test Plan:
- Load the program below with writeInst=1 while reset=0, then release reset:
  - 0:0x2128000A, 4:0x21290002, 8:0x01095000, 12:0x01084000, 16:0x010A5801
  - 20:0xAD0B0004, 24:0x4D0C0004, 28:0x116C0001, 32:0x016C5801, 36:0x016C5800
- Cycles 0-4 -> (write_reg, write_data) = (8,10), (9,2), (10,12), (8,20), (11,8).
- sw at PC=20 -> dmem word at byte address 24 = 8. lw at PC=24 -> write_reg=12, write_data=8.
- beq at PC=28 with $11=$12=8 -> next PC=36, skipping 32. Then add at 36 -> write_reg=11, write_data=16.
- Modified beq with unequal registers -> PC goes 28->32; sub executes.
- addi $0,$0,5 -> read of $0 stays 0.
- Assert reset mid-run -> ProgramCounter=0 immediately; registers read 0; instruction memory contents preserved.

Source files
------------

// File: rtl/mips_core.sv
// Single-cycle 32-bit MIPS-subset core with a loadable instruction memory.
// Fetch, decode, register read, ALU, data memory and write-back complete in one clock.
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous active-low reset (clears PC, registers, data memory)
//   inputInstruction  instruction word to load into instruction memory
//   writeInst         instruction memory write enable
//   instAddress       byte address of the instruction load
//   ProgramCounter    current PC (byte address)
//   wordIn            instruction fetched at the current PC (combinational)
//   write_reg         destination register index of the current instruction
//   write_data        register write-back bus value
module mips_core #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inputInstruction,
  input  logic        writeInst,
  input  logic [31:0] instAddress,
  output logic [31:0] ProgramCounter,
  output logic [31:0] wordIn,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LW2   = 6'b010011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD   = 6'b000000;
  localparam logic [5:0] FN_ADD2  = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b000001;
  localparam logic [5:0] FN_SUB2  = 6'b100010;

  logic [31:0] r_imem [IMEM_WORDS];
  logic [31:0] r_dmem [DMEM_WORDS];
  logic [31:0] r_regs [32];
  logic [31:0] r_pc;

  logic [31:0] w_inst;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [31:0] w_imm;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_alu_res;
  logic [31:0] w_load_data;
  logic [4:0]  w_wreg;
  logic        w_reg_we;
  logic        w_mem_we;
  logic        w_is_load;
  logic        w_branch;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic [DAW-1:0] w_daddr;
  logic        w_unused;

  // Field decode and register read
  assign w_inst   = r_imem[r_pc[IAW+1:2]];
  assign w_op     = w_inst[31:26];
  assign w_rs     = w_inst[25:21];
  assign w_rt     = w_inst[20:16];
  assign w_rd     = w_inst[15:11];
  assign w_funct  = w_inst[5:0];
  assign w_imm    = {{16{w_inst[15]}}, w_inst[15:0]};
  assign w_rs_val = r_regs[w_rs];
  assign w_rt_val = r_regs[w_rt];

  // Control and ALU; unknown opcodes/functs fall through as NOPs
  always_comb begin
    w_alu_res = w_rs_val + w_rt_val;
    w_wreg    = 5'd0;
    w_reg_we  = 1'b0;
    w_mem_we  = 1'b0;
    w_is_load = 1'b0;
    w_branch  = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD, FN_ADD2: begin
            w_alu_res = w_rs_val + w_rt_val;
            w_wreg    = w_rd;
            w_reg_we  = 1'b1;
          end
          FN_SUB, FN_SUB2: begin
            w_alu_res = w_rs_val - w_rt_val;
            w_wreg    = w_rd;
            w_reg_we  = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        w_alu_res = w_rs_val + w_imm;
        w_wreg    = w_rt;
        w_reg_we  = 1'b1;
      end
      OP_SW: begin
        w_alu_res = w_rs_val + w_imm;
        w_mem_we  = 1'b1;
      end
      OP_LW, OP_LW2: begin
        w_alu_res = w_rs_val + w_imm;
        w_wreg    = w_rt;
        w_reg_we  = 1'b1;
        w_is_load = 1'b1;
      end
      OP_BEQ: begin
        w_alu_res = w_rs_val - w_rt_val;
        w_branch  = (w_rs_val == w_rt_val);
      end
      default: ;
    endcase
  end

  assign w_daddr     = w_alu_res[DAW+1:2];
  assign w_load_data = r_dmem[w_daddr];
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_pc_next   = w_branch ? (w_pc_plus4 + {w_imm[29:0], 2'b00}) : w_pc_plus4;

  assign ProgramCounter = r_pc;
  assign wordIn         = w_inst;
  assign write_reg      = w_wreg;
  assign write_data     = w_is_load ? w_load_data : w_alu_res;

  // Bits that the decode deliberately ignores (shamt, unused address bits)
  assign w_unused = ^{instAddress[31:IAW+2], instAddress[1:0], w_inst[10:6]};

  // Instruction memory load port; independent of reset and never cleared
  always_ff @(posedge clk) begin
    if (writeInst) begin
      r_imem[instAddress[IAW+1:2]] <= inputInstruction;
    end
  end

  // Program counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Register file; $0 is never written so it stays at its reset value of zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_reg_we && (w_wreg != 5'd0)) begin
      r_regs[w_wreg] <= write_data;
    end
  end

  // Data memory: synchronous write, combinational read, cleared on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        r_dmem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_dmem[w_daddr] <= w_rt_val;
    end
  end

endmodule

// File: tb/tb_mips_core.sv
// Self-checking bench for mips_core: directed program table, multi-cycle corner
// sequences, and random programs compared against an instruction-level model.
module tb_mips_core;

  logic        clk;
  logic        reset;
  logic [31:0] inputInstruction;
  logic        writeInst;
  logic [31:0] instAddress;
  logic [31:0] ProgramCounter;
  logic [31:0] wordIn;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int checks;
  int failures;

  mips_core dut (
    .clk              (clk),
    .reset            (reset),
    .inputInstruction (inputInstruction),
    .writeInst        (writeInst),
    .instAddress      (instAddress),
    .ProgramCounter   (ProgramCounter),
    .wordIn           (wordIn),
    .write_reg        (write_reg),
    .write_data       (write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    bit          chk_data;
  } vec_t;

  vec_t tbl [10];

  logic [31:0] prog [11];

  // Instruction-level reference state
  logic [31:0] m_imem [64];
  logic [31:0] m_dmem [64];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge; the word is written on the following posedge
  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    instAddress      = a;
    inputInstruction = d;
    writeInst        = 1'b1;
    @(negedge clk);
    writeInst        = 1'b0;
    m_imem[(a >> 2) % 64] = d;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    @(negedge clk);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    #1;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 64; i++) m_dmem[i] = 32'd0;
  endtask

  // Executes one instruction of the model; reports what the DUT should show now
  task automatic model_step(output logic [4:0] e_wreg, output logic [31:0] e_wdata,
                            output bit c_wreg, output bit c_data);
    logic [31:0] ins, a, b, simm, addr, val;
    int op, rs, rt, rd, fn;
    bit wr;
    int dest;
    ins  = m_imem[(m_pc >> 2) % 64];
    op   = int'(ins >> 26);
    rs   = int'((ins >> 21) & 32'd31);
    rt   = int'((ins >> 16) & 32'd31);
    rd   = int'((ins >> 11) & 32'd31);
    fn   = int'(ins & 32'd63);
    a    = m_regs[rs];
    b    = m_regs[rt];
    simm = 32'($signed(ins[15:0]));
    e_wreg = 5'd0; e_wdata = 32'd0; c_wreg = 1'b1; c_data = 1'b0;
    wr = 1'b0; dest = 0; val = 32'd0;
    if (op == 0 && (fn == 0 || fn == 32)) begin
      dest = rd; val = a + b; wr = 1'b1;
    end else if (op == 0 && (fn == 1 || fn == 34)) begin
      dest = rd; val = a - b; wr = 1'b1;
    end else if (op == 0) begin
      c_wreg = 1'b0;
    end else if (op == 8) begin
      dest = rt; val = a + simm; wr = 1'b1;
    end else if (op == 43) begin
      addr = a + simm;
      m_dmem[(addr >> 2) % 64] = b;
      e_wdata = addr; c_data = 1'b1;
    end else if (op == 35 || op == 19) begin
      addr = a + simm;
      dest = rt; val = m_dmem[(addr >> 2) % 64]; wr = 1'b1;
    end else if (op == 4) begin
      if (a == b) m_pc = m_pc + (simm * 4);
    end
    if (wr) begin
      e_wreg = 5'(dest); e_wdata = val; c_data = 1'b1;
      if (dest != 0) m_regs[dest] = val;
    end
    m_pc = m_pc + 32'd4;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    int o;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 7))
      0: return {6'd0, rs, rt, rd, 5'd0, ($urandom_range(0, 1) == 0) ? 6'd0 : 6'd32};
      1: return {6'd0, rs, rt, rd, 5'd0, ($urandom_range(0, 1) == 0) ? 6'd1 : 6'd34};
      2: return {6'd8, rs, rt, imm};
      3: return {6'd43, rs, rt, imm};
      4: return {($urandom_range(0, 1) == 0) ? 6'd35 : 6'd19, rs, rt, imm};
      5: begin
        o = int'($urandom_range(0, 6)) - 3;
        return {6'd4, rs, rt, o[15:0]};
      end
      6: return {6'd15, rs, rt, imm};
      default: return {6'd0, rs, rt, rd, 5'd0, 6'd42};
    endcase
  endfunction

  initial begin
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    bit          c_wreg, c_data;

    checks = 0; failures = 0;
    reset = 1'b0; writeInst = 1'b0; instAddress = '0; inputInstruction = '0;

    prog[0] = 32'h2128000A; prog[1] = 32'h21290002; prog[2] = 32'h01095000;
    prog[3] = 32'h01084000; prog[4] = 32'h010A5801; prog[5] = 32'hAD0B0004;
    prog[6] = 32'h4D0C0004; prog[7] = 32'h116C0001; prog[8] = 32'h016C5801;
    prog[9] = 32'h016C5800; prog[10] = 32'h8C010018;

    tbl[0] = '{32'd0,  5'd8,  32'd10, 1'b1};
    tbl[1] = '{32'd4,  5'd9,  32'd2,  1'b1};
    tbl[2] = '{32'd8,  5'd10, 32'd12, 1'b1};
    tbl[3] = '{32'd12, 5'd8,  32'd20, 1'b1};
    tbl[4] = '{32'd16, 5'd11, 32'd8,  1'b1};
    tbl[5] = '{32'd20, 5'd0,  32'd24, 1'b1};
    tbl[6] = '{32'd24, 5'd12, 32'd8,  1'b1};
    tbl[7] = '{32'd28, 5'd0,  32'd0,  1'b0};
    tbl[8] = '{32'd36, 5'd11, 32'd16, 1'b1};
    tbl[9] = '{32'd40, 5'd1,  32'd8,  1'b1};

    #2;
    chk("reset_pc", ProgramCounter, 32'd0);

    // Directed program, loaded while held in reset
    @(negedge clk);
    for (int i = 0; i < 64; i++) load_word(32'(i * 4), 32'd0);
    for (int i = 0; i < 11; i++) load_word(32'(i * 4), prog[i]);
    release_reset();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tbl%0d_pc", i), ProgramCounter, tbl[i].pc);
      chk($sformatf("tbl%0d_wreg", i), 32'(write_reg), 32'(tbl[i].wreg));
      if (tbl[i].chk_data) chk($sformatf("tbl%0d_wdata", i), write_data, tbl[i].wdata);
      chk($sformatf("tbl%0d_word", i), wordIn, m_imem[tbl[i].pc[7:2]]);
      next_cycle();
    end

    // Asynchronous reset mid-run, imem preserved, regs/dmem cleared
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_pc", ProgramCounter, 32'd0);
    chk("midreset_imem", wordIn, 32'h2128000A);
    @(negedge clk);
    load_word(32'd0, 32'h8C010018);
    release_reset();
    chk("post_reset_lw_wreg", 32'(write_reg), 32'd1);
    chk("post_reset_lw_dmem", write_data, 32'd0);
    next_cycle();
    chk("post_reset_pc", ProgramCounter, 32'd4);
    chk("post_reset_reg9", write_data, 32'd2);

    // beq with unequal registers falls through to the sub at 32
    enter_reset();
    load_word(32'd0, 32'h2128000A);
    load_word(32'd28, 32'h11680001);
    release_reset();
    for (int i = 0; i < 7; i++) next_cycle();
    chk("beq_nt_pc28", ProgramCounter, 32'd28);
    chk("beq_nt_wreg", 32'(write_reg), 32'd0);
    next_cycle();
    chk("beq_nt_pc32", ProgramCounter, 32'd32);
    chk("beq_nt_sub_wreg", 32'(write_reg), 32'd11);
    chk("beq_nt_sub_wdata", write_data, 32'd0);

    // Writes to $0 are discarded
    enter_reset();
    load_word(32'd0, 32'h20000005);
    load_word(32'd4, 32'h00000820);
    release_reset();
    chk("zero_addi_wreg", 32'(write_reg), 32'd0);
    chk("zero_addi_wdata", write_data, 32'd5);
    next_cycle();
    chk("zero_read_wreg", 32'(write_reg), 32'd1);
    chk("zero_read_wdata", write_data, 32'd0);

    // Random programs against the model
    for (int r = 0; r < 3; r++) begin
      enter_reset();
      for (int i = 0; i < 64; i++) load_word(32'(i * 4), rand_inst());
      release_reset();
      for (int c = 0; c < 150; c++) begin
        chk($sformatf("rnd%0d_%0d_pc", r, c), ProgramCounter, m_pc);
        chk($sformatf("rnd%0d_%0d_word", r, c), wordIn, m_imem[(m_pc >> 2) % 64]);
        model_step(e_wreg, e_wdata, c_wreg, c_data);
        if (c_wreg) chk($sformatf("rnd%0d_%0d_wreg", r, c), 32'(write_reg), 32'(e_wreg));
        if (c_data) chk($sformatf("rnd%0d_%0d_wdata", r, c), write_data, e_wdata);
        next_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
